cp0_intr_ctrl: RTL and testbench

CP0_INTR_CTRL -- requirements
Module: cp0_intr_ctrl

---
 rtl/cp0_pkg.sv | 25 ++
 rtl/cp0_regfile.sv | 63 ++++++
 rtl/cp0_intr_ctrl.sv | 107 ++++++++++
 tb/tb_cp0_intr_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, exception codes, PC-select encodings, FSM states.
package cp0_pkg;

  localparam logic [31:0] EXC_BASE = 32'h0000_0008;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_EPC = 2'b01,
    SEL_EXC = 2'b10
  } selpc_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACK      = 2'b01,
    ST_WAIT_LOW = 2'b10
  } state_e;

endpackage

// File: rtl/cp0_regfile.sv
// CP0 Status/Cause/EPC storage with mtc0 write port and combinational read mux.
// Hardware updates (exception take, eret) override a same-cycle mtc0 write.
module cp0_regfile
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        exc_take,
  input  logic [4:0]  exc_code,
  input  logic        exc_bd,
  input  logic [31:0] exc_epc,
  input  logic        eret_do,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rdata,
  output logic [7:0]  status,
  output logic [31:0] epc
);

  logic [4:0] cause_code;
  logic       cause_bd;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      status     <= 8'h00;
      cause_code <= 5'd0;
      cause_bd   <= 1'b0;
      epc        <= 32'h0;
    end else begin
      // Status keeps a two-deep stack of 4-bit levels; take pushes, eret pops.
      if (exc_take)
        status <= {status[3:0], 4'b0000};
      else if (eret_do)
        status <= {4'b0000, status[7:4]};
      else if (wr_en && wr_addr == REG_STATUS)
        status <= wdata[7:0];

      // Cause is hardware-owned; software writes are dropped.
      if (exc_take) begin
        cause_code <= exc_code;
        cause_bd   <= exc_bd;
      end

      if (exc_take)
        epc <= exc_epc;
      else if (wr_en && wr_addr == REG_EPC)
        epc <= wdata;
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (rd_addr)
      REG_STATUS: rdata = {24'h0, status};
      REG_CAUSE:  rdata = {cause_bd, 24'h0, cause_code, 2'b00};
      REG_EPC:    rdata = epc;
      default:    rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/cp0_intr_ctrl.sv
// CP0 interrupt controller: take logic, acknowledge FSM, PC redirect.
// Optional syscall exception enabled by defining CP0_SYSCALL_EN.
//
// state    | meaning
// IDLE     | no handshake in flight; interrupt may be taken
// ACK      | one-cycle inta pulse after a take
// WAIT_LOW | wait for intr to drop before allowing a re-take
module cp0_intr_ctrl
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        intr,
  output logic        inta,
  input  logic        stall,
  input  logic [31:0] id_npc,
  input  logic        id_in_slot,
  input  logic        mtc0,
  input  logic        mfc0,
  input  logic        eret,
  input  logic [4:0]  cp0_rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [1:0]  selpc,
  output logic [31:0] epc,
`ifdef CP0_SYSCALL_EN
  input  logic        syscall,
`endif
  output logic        cancel
);

  state_e      state_q, state_d;
  selpc_e      sel;
  logic        run;
  logic        sys_take;
  logic        int_take;
  logic        exc_take;
  logic        eret_do;
  logic [4:0]  exc_code;
  logic [7:0]  status;
  logic [31:0] reg_rdata;

  // Outputs stay quiet while stalled or held in reset.
  assign run = clrn & ~stall;

`ifdef CP0_SYSCALL_EN
  assign sys_take = run & syscall;
  assign exc_code = sys_take ? EXC_SYS : EXC_INT;
`else
  assign sys_take = 1'b0;
  assign exc_code = EXC_INT;
`endif

  assign eret_do  = run & eret;
  assign int_take = (state_q == ST_IDLE) & run & intr & status[0] &
                    ~id_in_slot & ~eret & ~sys_take;
  assign exc_take = int_take | sys_take;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    inta    = 1'b0;
    sel     = SEL_SEQ;
    cancel  = 1'b0;
    case (state_q)
      ST_IDLE:     if (int_take) state_d = ST_ACK;
      ST_ACK: begin
        inta    = run;
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: if (!intr) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (exc_take) begin
      sel    = SEL_EXC;
      cancel = 1'b1;
    end else if (eret_do) begin
      sel    = SEL_EPC;
      cancel = 1'b1;
    end
  end

  assign selpc = sel;
  assign rdata = mfc0 ? reg_rdata : 32'h0;

  cp0_regfile u_regfile (
    .clk      (clk),
    .clrn     (clrn),
    .exc_take (exc_take),
    .exc_code (exc_code),
    .exc_bd   (id_in_slot),
    .exc_epc  (id_npc),
    .eret_do  (eret_do),
    .wr_en    (run & mtc0),
    .wr_addr  (cp0_rd),
    .wdata    (wdata),
    .rd_addr  (cp0_rd),
    .rdata    (reg_rdata),
    .status   (status),
    .epc      (epc)
  );

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Directed self-checking bench for cp0_intr_ctrl; syscall steps build when CP0_SYSCALL_EN is defined.
module tb_cp0_intr_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic        intr;
  logic        inta;
  logic        stall;
  logic [31:0] id_npc;
  logic        id_in_slot;
  logic        mtc0;
  logic        mfc0;
  logic        eret;
  logic [4:0]  cp0_rd;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  selpc;
  logic [31:0] epc;
  logic        cancel;
`ifdef CP0_SYSCALL_EN
  logic        syscall;
`endif

  int checks;
  int failures;

  always #5 clk = ~clk;

  cp0_intr_ctrl dut (
    .clk        (clk),
    .clrn       (clrn),
    .intr       (intr),
    .inta       (inta),
    .stall      (stall),
    .id_npc     (id_npc),
    .id_in_slot (id_in_slot),
    .mtc0       (mtc0),
    .mfc0       (mfc0),
    .eret       (eret),
    .cp0_rd     (cp0_rd),
    .wdata      (wdata),
    .rdata      (rdata),
    .selpc      (selpc),
    .epc        (epc),
`ifdef CP0_SYSCALL_EN
    .syscall    (syscall),
`endif
    .cancel     (cancel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    mfc0   = 1'b1;
    cp0_rd = addr;
    #1;
    v      = rdata;
    mfc0   = 1'b0;
    chk(tag, v, exp);
  endtask

  task automatic wr_reg(input logic [4:0] addr, input logic [31:0] d);
    mtc0   = 1'b1;
    cp0_rd = addr;
    wdata  = d;
    tick();
    mtc0   = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    clrn = 1'b0; intr = 1'b1; eret = 1'b1; stall = 1'b0; id_npc = 32'h0;
    id_in_slot = 1'b0; mtc0 = 1'b0; mfc0 = 1'b0; cp0_rd = 5'd0; wdata = 32'h0;
`ifdef CP0_SYSCALL_EN
    syscall = 1'b0;
`endif
    tick(); tick();
    chk("rst_selpc", selpc, 32'd0);
    chk("rst_cancel", cancel, 32'd0);
    chk("rst_inta", inta, 32'd0);
    chk("rst_epc", epc, 32'h0);
    eret = 1'b0; intr = 1'b0;
    chk_reg("rst_status", 5'd12, 32'h0);
    chk_reg("rst_cause", 5'd13, 32'h0);
    clrn = 1'b1;

    // IE clear: interrupt ignored
    intr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ie0_selpc", selpc, 32'd0);
      chk("ie0_inta", inta, 32'd0);
      tick();
    end
    chk("ie0_epc", epc, 32'h0);
    intr = 1'b0;

    // first take
    wr_reg(5'd12, 32'h1);
    chk_reg("ie_set", 5'd12, 32'h1);
    intr = 1'b1; id_npc = 32'h24; #1;
    chk("take1_selpc", selpc, 32'd2);
    chk("take1_cancel", cancel, 32'd1);
    chk("take1_inta_pre", inta, 32'd0);
    tick();
    chk("take1_epc", epc, 32'h24);
    chk_reg("take1_status", 5'd12, 32'h10);
    chk("take1_inta", inta, 32'd1);
    chk("take1_selpc_after", selpc, 32'd0);
    tick();
    chk("take1_inta_one", inta, 32'd0);

    // intr held, IE re-enabled: no re-take until intr drops
    wr_reg(5'd12, 32'h11);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_selpc", selpc, 32'd0);
      chk("hold_inta", inta, 32'd0);
      tick();
    end
    intr = 1'b0; tick();
    intr = 1'b1; id_npc = 32'h30; #1;
    chk("retake_selpc", selpc, 32'd2);
    tick();
    chk("retake_epc", epc, 32'h30);
    chk("retake_inta", inta, 32'd1);
    intr = 1'b0; tick(); tick();
    chk_reg("retake_status", 5'd12, 32'h10);

    // eret restores saved level
    eret = 1'b1; #1;
    chk("eret_selpc", selpc, 32'd1);
    chk("eret_cancel", cancel, 32'd1);
    tick();
    eret = 1'b0;
    chk_reg("eret_status", 5'd12, 32'h01);

    // delay slot defers the take
    intr = 1'b1; id_in_slot = 1'b1; id_npc = 32'h50; #1;
    chk("slot1_selpc", selpc, 32'd0);
    tick();
    id_npc = 32'h54; #1;
    chk("slot2_selpc", selpc, 32'd0);
    tick();
    id_in_slot = 1'b0; id_npc = 32'h58; #1;
    chk("slot3_selpc", selpc, 32'd2);
    tick();
    chk("slot_epc", epc, 32'h58);
    chk("slot_inta", inta, 32'd1);
    chk_reg("slot_cause", 5'd13, 32'h0);
    intr = 1'b0; tick(); tick();

    // eret wins over intr, intr taken next cycle
    intr = 1'b1; eret = 1'b1; #1;
    chk("eret_intr_selpc", selpc, 32'd1);
    tick();
    eret = 1'b0;
    chk_reg("eret_intr_status", 5'd12, 32'h01);
    id_npc = 32'h60; #1;
    chk("after_eret_selpc", selpc, 32'd2);
    tick();
    chk("after_eret_epc", epc, 32'h60);
    chk("after_eret_inta", inta, 32'd1);
    intr = 1'b0; tick(); tick();

    // stall blocks mtc0 commit and exception take
    stall = 1'b1; mtc0 = 1'b1; cp0_rd = 5'd14; wdata = 32'hDEAD; #1;
    chk("stall_selpc", selpc, 32'd0);
    chk("stall_cancel", cancel, 32'd0);
    tick();
    chk("stall_epc_hold", epc, 32'h60);
    stall = 1'b0; tick();
    mtc0 = 1'b0;
    chk("mtc0_epc", epc, 32'hDEAD);
    wr_reg(5'd12, 32'h1);
    stall = 1'b1; intr = 1'b1; #1;
    chk("stall_int_selpc", selpc, 32'd0);
    chk("stall_int_cancel", cancel, 32'd0);
    tick();
    chk("stall_int_inta", inta, 32'd0);
    chk("stall_int_epc", epc, 32'hDEAD);

    // take beats a same-cycle mtc0 to EPC
    stall = 1'b0; mtc0 = 1'b1; cp0_rd = 5'd14; wdata = 32'h1234; id_npc = 32'h70; #1;
    chk("hw_win_selpc", selpc, 32'd2);
    tick();
    mtc0 = 1'b0;
    chk("hw_win_epc", epc, 32'h70);
    chk("hw_win_inta", inta, 32'd1);
    intr = 1'b0; tick(); tick();

    // masked / read-only / unmapped
    wr_reg(5'd12, 32'hFFFF_FFFF);
    chk_reg("status_mask", 5'd12, 32'hFF);
    wr_reg(5'd13, 32'hFFFF_FFFF);
    chk_reg("cause_ro", 5'd13, 32'h0);
    chk_reg("unmapped", 5'd5, 32'h0);

    // reset during ACK aborts the handshake
    wr_reg(5'd12, 32'h1);
    intr = 1'b1; id_npc = 32'h80; tick();
    chk("pre_rst_inta", inta, 32'd1);
    clrn = 1'b0; #1;
    chk("mid_rst_inta", inta, 32'd0);
    chk("mid_rst_epc", epc, 32'h0);
    tick();
    clrn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_inta", inta, 32'd0);
    end
    chk_reg("post_rst_status", 5'd12, 32'h0);
    intr = 1'b0;

`ifdef CP0_SYSCALL_EN
    syscall = 1'b1; id_npc = 32'h40; #1;
    chk("sys_selpc", selpc, 32'd2);
    chk("sys_cancel", cancel, 32'd1);
    tick();
    syscall = 1'b0;
    chk("sys_epc", epc, 32'h40);
    chk("sys_inta", inta, 32'd0);
    chk_reg("sys_cause", 5'd13, 32'h20);
    wr_reg(5'd12, 32'h1);
    syscall = 1'b1; intr = 1'b1; id_npc = 32'h44; #1;
    chk("sys_win_selpc", selpc, 32'd2);
    tick();
    syscall = 1'b0; intr = 1'b0;
    chk("sys_win_epc", epc, 32'h44);
    chk("sys_win_inta", inta, 32'd0);
    chk_reg("sys_win_cause", 5'd13, 32'h20);
    tick();
    chk("sys_win_inta2", inta, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
